// File: rtl/wb_master_bridge.sv
// wb_master_bridge: single-outstanding CPU request to Wishbone master bridge with ACK timeout
module wb_master_bridge #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_done,
    output logic        cpu_err,
    output logic        cpu_busy,
    output logic        wb_STB,
    output logic        wb_WE,
    output logic [31:0] wb_ADDR,
    output logic [31:0] wb_DAT_O,
    input  logic [31:0] wb_DAT_I,
    input  logic        wb_ACK
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUS  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [1:0] ERR  = 2'd3;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    logic [1:0]  state;
    logic [1:0]  nxt;
    logic [15:0] cnt;

    // next state: ACK is checked before the timeout so a late ACK still completes
    always_comb begin
        nxt = (state == IDLE) ? (cpu_req ? ((|cpu_addr[1:0]) ? ERR : BUS) : IDLE)
            : (state == BUS)  ? (wb_ACK ? DONE : (cnt == TO_LAST) ? ERR : BUS)
            : IDLE;
    end

    // state, counter and every output are registered from the next-state decode
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            wb_STB    <= 1'b0;
            wb_WE     <= 1'b0;
            wb_ADDR   <= '0;
            wb_DAT_O  <= '0;
            cpu_rdata <= '0;
            cpu_done  <= 1'b0;
            cpu_err   <= 1'b0;
            cpu_busy  <= 1'b0;
        end else begin
            state    <= nxt;
            cnt      <= (state == BUS && nxt == BUS) ? cnt + 16'd1 : '0;
            wb_STB   <= nxt == BUS;
            cpu_busy <= nxt != IDLE;
            cpu_done <= nxt == DONE;
            cpu_err  <= nxt == ERR;
            if (state == IDLE && nxt == BUS) begin
                wb_WE    <= cpu_we;
                wb_ADDR  <= cpu_addr;
                wb_DAT_O <= cpu_wdata;
            end
            if (state == BUS && wb_ACK && !wb_WE)
                cpu_rdata <= wb_DAT_I;
        end
    end
endmodule

// File: tb/tb_wb_master_bridge.sv
// tb_wb_master_bridge: randomized and directed checks of the bridge against a transaction-level model
module tb_wb_master_bridge;
    localparam int T = 16;

    logic        clk = 0;
    logic        rst = 1;
    logic        cpu_req = 0;
    logic        cpu_we = 0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_done;
    logic        cpu_err;
    logic        cpu_busy;
    logic        wb_STB;
    logic        wb_WE;
    logic [31:0] wb_ADDR;
    logic [31:0] wb_DAT_O;
    logic [31:0] wb_DAT_I = '0;
    logic        wb_ACK = 0;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_rdata = '0;

    wb_master_bridge #(.TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_err(cpu_err),
        .cpu_busy(cpu_busy), .wb_STB(wb_STB), .wb_WE(wb_WE), .wb_ADDR(wb_ADDR),
        .wb_DAT_O(wb_DAT_O), .wb_DAT_I(wb_DAT_I), .wb_ACK(wb_ACK)
    );

    always #5 clk = ~clk;

    // Issues one request and plays a slave that ACKs on STB cycle ack_at (none if out of range).
    // Cycle numbers count from the accepting edge; observations only, no verdicts here.
    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int ack_at, input logic [31:0] rd,
                          output int stb_n, output int done_n, output int err_n, output int lat,
                          output int attr_bad, output int busy_bad, output int idle_after);
        stb_n = 0; done_n = 0; err_n = 0; lat = -1; attr_bad = 0; busy_bad = 0; idle_after = 0;
        @(posedge clk); #1;
        cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        @(posedge clk); #1;
        cpu_req = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (cpu_done) done_n++;
            if (cpu_err) err_n++;
            if (lat > 0 && c == lat + 1) begin
                idle_after = !cpu_busy;
                break;
            end
            if ((cpu_done || cpu_err) && lat < 0) lat = c;
            if (lat < 0 && !cpu_busy) busy_bad++;
            if (wb_STB) begin
                stb_n++;
                if (wb_WE !== we || wb_ADDR !== addr || wb_DAT_O !== wdata) attr_bad++;
                wb_ACK = (stb_n == ack_at);
                wb_DAT_I = rd;
            end else begin
                wb_ACK = 1'($urandom_range(0, 1));
                wb_DAT_I = $urandom;
            end
        end
        wb_ACK = 0;
    endtask

    // Runs one transaction and compares it with the transaction-level expectation
    task automatic run_and_check(input string name, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int ack_at, input logic [31:0] rd);
        int stb_n, done_n, err_n, lat, attr_bad, busy_bad, idle_after;
        int e_stb, e_lat, e_done, e_err;
        if (addr[1:0] != 2'b00) begin
            e_stb = 0; e_lat = 1; e_done = 0; e_err = 1;
        end else if (ack_at >= 1 && ack_at <= T) begin
            e_stb = ack_at; e_lat = ack_at + 1; e_done = 1; e_err = 0;
            if (!we) exp_rdata = rd;
        end else begin
            e_stb = T; e_lat = T + 1; e_done = 0; e_err = 1;
        end
        do_txn(we, addr, wdata, ack_at, rd, stb_n, done_n, err_n, lat, attr_bad, busy_bad, idle_after);
        checks++;
        if (stb_n !== e_stb) begin
            failures++; $display("FAIL %s stb_cycles got=%0d exp=%0d", name, stb_n, e_stb);
        end
        checks++;
        if (lat !== e_lat) begin
            failures++; $display("FAIL %s latency got=%0d exp=%0d", name, lat, e_lat);
        end
        checks++;
        if (done_n !== e_done || err_n !== e_err) begin
            failures++; $display("FAIL %s pulses got done=%0d err=%0d exp done=%0d err=%0d", name, done_n, err_n, e_done, e_err);
        end
        checks++;
        if (attr_bad !== 0) begin
            failures++; $display("FAIL %s bus_attrs bad_cycles=%0d exp=0", name, attr_bad);
        end
        checks++;
        if (busy_bad !== 0 || idle_after !== 1) begin
            failures++; $display("FAIL %s busy bad_cycles=%0d idle_after=%0d exp 0/1", name, busy_bad, idle_after);
        end
        checks++;
        if (cpu_rdata !== exp_rdata) begin
            failures++; $display("FAIL %s rdata got=%h exp=%h", name, cpu_rdata, exp_rdata);
        end
    endtask

    task automatic test_reset;
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({wb_STB, wb_WE, wb_ADDR, wb_DAT_O, cpu_rdata, cpu_done, cpu_err, cpu_busy} !== '0) begin
            failures++;
            $display("FAIL reset_state got stb=%b we=%b addr=%h dat=%h rdata=%h done=%b err=%b busy=%b exp all 0",
                     wb_STB, wb_WE, wb_ADDR, wb_DAT_O, cpu_rdata, cpu_done, cpu_err, cpu_busy);
        end
        rst = 0;
        exp_rdata = '0;
    endtask

    task automatic test_directed;
        run_and_check("read_ack1", 1'b0, 32'h2000_0010, 32'h0, 1, 32'hDEAD_BEEF);
        run_and_check("write_wait3", 1'b1, 32'h1000_0004, 32'h1234_5678, 3, 32'h5555_AAAA);
        run_and_check("timeout", 1'b0, 32'h3000_0000, 32'h0, 0, 32'h1111_2222);
        run_and_check("race_ack16", 1'b0, 32'h3000_0020, 32'h0, T, 32'hCAFE_F00D);
        run_and_check("misaligned", 1'b0, 32'h0000_0002, 32'h0, 1, 32'h9999_9999);
        run_and_check("ack_last_minus1", 1'b1, 32'h5000_0100, 32'hA5A5_5A5A, T - 1, 32'h0);
    endtask

    task automatic test_random;
        for (int i = 0; i < 20; i++) begin
            logic [31:0] addr;
            addr = $urandom;
            if ($urandom_range(0, 4) != 0) addr[1:0] = 2'b00;
            run_and_check($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), addr, $urandom,
                          $urandom_range(0, T + 3), $urandom);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] last;
        @(posedge clk); #1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h4000_0008; cpu_wdata = 32'h0;
        @(posedge clk); #1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            checks++;
            if (wb_STB !== (c % 3 == 1) || cpu_done !== (c % 3 == 2) || cpu_busy !== (c % 3 != 0)) begin
                failures++;
                $display("FAIL b2b cycle%0d got stb=%b done=%b busy=%b exp stb=%b done=%b busy=%b", c,
                         wb_STB, cpu_done, cpu_busy, c % 3 == 1, c % 3 == 2, c % 3 != 0);
            end
            wb_ACK = wb_STB;
            wb_DAT_I = 32'hA500_0000 | c;
            if (wb_STB) last = wb_DAT_I;
        end
        cpu_req = 0;
        wb_ACK = 0;
        exp_rdata = last;
        checks++;
        if (cpu_rdata !== exp_rdata) begin
            failures++; $display("FAIL b2b_rdata got=%h exp=%h", cpu_rdata, exp_rdata);
        end
    endtask

    task automatic test_reset_mid;
        int pulses;
        pulses = 0;
        @(posedge clk); #1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h6000_0040; cpu_wdata = 32'h0;
        @(posedge clk); #1;
        cpu_req = 0;
        wb_ACK = 0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (wb_STB !== 1'b1) begin
            failures++; $display("FAIL rst_mid_pre stb got=%b exp=1", wb_STB);
        end
        rst = 1;
        @(negedge clk);
        checks++;
        if (wb_STB !== 1'b0 || cpu_busy !== 1'b0 || cpu_rdata !== 32'h0) begin
            failures++; $display("FAIL rst_mid_post got stb=%b busy=%b rdata=%h exp 0/0/0", wb_STB, cpu_busy, cpu_rdata);
        end
        rst = 0;
        exp_rdata = '0;
        for (int c = 0; c < 4; c++) begin
            if (cpu_done || cpu_err) pulses++;
            @(negedge clk);
        end
        checks++;
        if (pulses !== 0) begin
            failures++; $display("FAIL rst_mid_pulses got=%0d exp=0", pulses);
        end
        run_and_check("after_rst", 1'b0, 32'h7000_0000, 32'h0, 2, 32'h0BAD_F00D);
    endtask

    initial begin
        test_reset;
        test_directed;
        test_back_to_back;
        test_random;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wb_master_bridge.md
WB_MASTER_BRIDGE -- requirements
Module: wb_master_bridge

Interface
REQ-001 SHALL have parameter: TIMEOUT, 16, number of cycles the strobe is held without ACK before the bus error (legal range 2..65535).
REQ-002 SHALL have port: clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: cpu_req  input  1  request, sampled only in IDLE.
REQ-005 SHALL have port: cpu_we  input  1  1 = write, 0 = read.
REQ-006 SHALL have port: cpu_addr  input  32  byte address; bits [31:28] select the slave downstream.
REQ-007 SHALL have port: cpu_wdata  input  32  write data.
REQ-008 SHALL have port: cpu_rdata  output  32  read data, held until the next successful read.
REQ-009 SHALL have port: cpu_done  output  1  one-cycle pulse on successful completion.
REQ-010 SHALL have port: cpu_err  output  1  one-cycle pulse on timeout or misaligned request.
REQ-011 SHALL have port: cpu_busy  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port: wb_STB  output  1  bus strobe, to interconnect master_STB.
REQ-013 SHALL have port: wb_WE  output  1  bus write enable.
REQ-014 SHALL have port: wb_ADDR  output  32  bus address.
REQ-015 SHALL have port: wb_DAT_O  output  32  bus write data.
REQ-016 SHALL have port: wb_DAT_I  input  32  bus read data.
REQ-017 SHALL have port: wb_ACK  input  1  bus acknowledge.

Function
REQ-018 SHALL implement states IDLE, BUS, DONE, ERR; all outputs registered.
REQ-019 In IDLE with cpu_req=1 and cpu_addr[1:0]=0, SHALL latch cpu_we/cpu_addr/cpu_wdata and enter BUS; wb_STB rises the following cycle.
REQ-020 In IDLE with cpu_req=1 and cpu_addr[1:0]!=0, SHALL enter ERR without asserting wb_STB.
REQ-021 In BUS, wb_STB=1 and wb_WE/wb_ADDR/wb_DAT_O SHALL hold the latched values, stable for the whole cycle.
REQ-022 In BUS, wb_ACK=1 at a rising edge SHALL move to DONE; if latched we=0, wb_DAT_I SHALL be captured into cpu_rdata at that edge.
REQ-023 Timeout counter (16 bits) SHALL clear on entry to BUS and increment each BUS cycle without ACK; on the TIMEOUT-th BUS cycle without ACK, SHALL enter ERR.
REQ-024 ACK arriving in the same cycle as the timeout condition SHALL win: transition to DONE, not ERR.
REQ-025 DONE SHALL last exactly one cycle with cpu_done=1, wb_STB=0, then go to IDLE.
REQ-026 ERR SHALL last exactly one cycle with cpu_err=1, wb_STB=0, cpu_rdata unchanged, then go to IDLE.
REQ-027 cpu_req while not in IDLE SHALL be ignored (not queued); the requester holds or reissues it.
REQ-028 wb_ACK while wb_STB=0 SHALL be ignored.
REQ-029 Minimum latency: req accepted at cycle 0, STB at cycle 1, ACK at cycle 1 -> cpu_done at cycle 2, next request accepted at cycle 3.
REQ-030 Writes SHALL leave cpu_rdata unchanged.

Reset
REQ-031 While rst=1 at a rising edge, SHALL enter IDLE and drive wb_STB=0, wb_WE=0, wb_ADDR=0, wb_DAT_O=0, cpu_rdata=0, cpu_done=0, cpu_err=0, cpu_busy=0, counter=0.
REQ-032 Reset asserted mid-transaction (BUS) SHALL drop wb_STB at that edge, abandon the transaction, and produce neither cpu_done nor cpu_err.

Verification
REQ-033 Read: cpu_req, we=0, addr=0x2000_0010; slave ACKs first STB cycle with 0xDEADBEEF -> wb_ADDR=0x2000_0010 at cycle 1, cpu_done and cpu_rdata=0xDEADBEEF at cycle 2.
REQ-034 Write with 3-cycle wait: we=1, addr=0x1000_0004, wdata=0x12345678; ACK on 3rd STB cycle -> STB high exactly 3 cycles, wb_WE=1, wb_DAT_O=0x12345678, cpu_done once, cpu_rdata unchanged.
REQ-035 Timeout: TIMEOUT=16, no ACK -> STB high exactly 16 cycles, cpu_err pulse next cycle, cpu_done never.
REQ-036 Race: ACK on 16th STB cycle with TIMEOUT=16 -> cpu_done, no cpu_err.
REQ-037 Misaligned addr=0x0000_0002 -> cpu_err one cycle after request, wb_STB never asserted.
REQ-038 rst pulsed on 2nd BUS cycle -> wb_STB=0 and cpu_busy=0 after that edge, no done/err pulse; a following request completes normally.
